dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 64-bit words in the storage array (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to rsp_valid (legal range 1..15).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  pipeline MEM stage presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store (MemWrite), 0 = load (MemRead).
REQ-008 req_addr  input  64  byte address from the ALU result.
REQ-009 req_wdata  input  64  store data (read_data2 path).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  pipeline accepts the response.
REQ-012 rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 rsp_error  output  1  request was misaligned or out of range.

Function
REQ-014 FSM states: IDLE, BUSY, RESP; req_ready SHALL equal (state == IDLE), combinationally.
REQ-015 Handshake: a request is accepted on a rising edge where req_valid && req_ready; addr, write flag and wdata are latched at that edge.
REQ-016 IDLE -> BUSY on acceptance when LATENCY > 1, loading the countdown with LATENCY-1; IDLE -> RESP directly when LATENCY == 1.
REQ-017 BUSY: the countdown decrements each cycle; BUSY -> RESP on the edge where the countdown equals 1.
REQ-018 rsp_valid SHALL assert exactly LATENCY cycles after the acceptance edge and hold, with stable rsp_rdata and rsp_error, until the edge where rsp_ready is 1; RESP -> IDLE on that edge.
REQ-019 rsp_valid SHALL be 1 only in RESP; rsp_ready outside RESP is ignored.
REQ-020 Back-to-back: req_ready is 0 in BUSY and RESP, so minimum request spacing is LATENCY+1 cycles; a request arriving while not IDLE SHALL stay pending until accepted (req_valid held by the initiator).
REQ-021 Word index = req_addr[3+log2(DEPTH)-1:3].
REQ-022 Error when req_addr[2:0] != 0 or req_addr[63:3+log2(DEPTH)] != 0; an errored request SHALL NOT modify storage, and SHALL return rsp_error = 1 and rsp_rdata = 0.
REQ-023 A store commits to the array on the edge entering RESP; a load samples the array on the same edge, so a load after a store to the same word returns the new data.
REQ-024 A store response SHALL carry rsp_rdata = 0 and rsp_error = 0.
REQ-025 Storage contents are not cleared by reset; they are zero-initialised at time 0 for simulation.

Reset
REQ-026 On an edge with reset = 1: state = IDLE, countdown = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, latched request cleared.
REQ-027 Reset in BUSY SHALL abandon the pending request; a pending store SHALL NOT commit.
REQ-028 Reset in RESP SHALL drop the response without waiting for rsp_ready; the array keeps any already-committed store.
REQ-029 req_ready is 1 from the first cycle after reset deasserts.

Structure
REQ-030 Shared package armv8_mem_pkg: FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2), the word width of 64, and the alignment-mask constant 3'b111.
REQ-031 One sub-module, dmem_array: a single-port DEPTH x 64 synchronous array with write enable, used by dmem_responder for storage; the FSM and countdown stay in dmem_responder.

Verification
REQ-032 Reset, then store addr 0x10 data 0xDEADBEEF_CAFEF00D, rsp_ready = 1 -> rsp_valid 2 cycles after acceptance with rdata = 0, error = 0; load 0x10 -> rdata = 0xDEADBEEF_CAFEF00D.
REQ-033 Load addr 0x13 (misaligned) -> rsp_error = 1, rdata = 0; store 0x800 with DEPTH = 256 -> rsp_error = 1, and a later load of word 0 is unchanged.
REQ-034 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rdata and error stay stable and req_ready stays 0; release -> IDLE on the next edge.
REQ-035 Issue a store to 0x20, then assert reset for one cycle while in BUSY -> no response; a subsequent load of 0x20 returns the old value (0).
REQ-036 Hold req_valid continuously for 4 loads, rsp_ready = 1, LATENCY = 1 and LATENCY = 3 -> acceptances spaced exactly 2 and 4 cycles apart respectively, responses in order.

Source files
------------

// File: rtl/armv8_mem_pkg.sv
// Shared constants and types for the data-memory responder.
package armv8_mem_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] ALIGN_MASK = 3'b111;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // Misaligned byte address or any bit set above the word-index field.
    function automatic logic addr_error(input logic [WORD_W-1:0] addr,
                                        input int unsigned idx_w);
        logic [WORD_W-1:0] hi;
        hi = addr >> (3 + idx_w);
        return ((addr[2:0] & ALIGN_MASK) != 3'd0) || (hi != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array; reads are registered, writes commit on the edge.
module dmem_array
    import armv8_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // Contents survive reset; the initialiser only gives simulation a known start.
    logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: valid/ready request, fixed-latency response over a word array.
module dmem_responder
    import armv8_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    mem_req_t          req_q;
    mem_req_t          cur;
    logic              load_ok;
    logic              accept;
    logic              enter_resp;
    logic              cur_err;
    logic              arr_en;
    logic [WORD_W-1:0] arr_rdata;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // With LATENCY == 1 the array is accessed on the acceptance edge, before the latch holds it.
    always_comb begin
        cur = req_q;
        if (state == ST_IDLE) begin
            cur = '{write: req_write, addr: req_addr, wdata: req_wdata};
        end
    end

    assign enter_resp = ((state == ST_IDLE) && accept && (LATENCY == 1))
                     || ((state == ST_BUSY) && (count == CNT_W'(1)));
    assign cur_err    = addr_error(cur.addr, IDX_W);
    assign arr_en     = enter_resp && !cur_err && !reset;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_BUSY;
                        count_nxt = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                count_nxt = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            req_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            load_ok   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) begin
                req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            end
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_error <= cur_err;
                load_ok   <= !cur_err && !cur.write;
            end else if ((state == ST_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_error <= 1'b0;
                load_ok   <= 1'b0;
            end
        end
    end

    // Array read register only changes on a load entering RESP, so the data holds through RESP.
    assign rsp_rdata = load_ok ? arr_rdata : '0;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clock (clock),
        .en    (arr_en),
        .we    (cur.write),
        .idx   (cur.addr[3 +: IDX_W]),
        .wdata (cur.wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, hold/reset sequences, back-to-back spacing, random vs. model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_write [NI];
    logic [63:0] req_addr  [NI];
    logic [63:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [63:0] rsp_rdata [NI];
    logic        rsp_error [NI];

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] mdl [NI][DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
        .clock(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_error(rsp_error[0]));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clock(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_error(rsp_error[1]));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
        .clock(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_error(rsp_error[2]));

    typedef struct {
        bit          w;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference behaviour: byte address -> word, error on misalignment or beyond DEPTH words.
    task automatic model(input int k, input bit w, input logic [63:0] a, input logic [63:0] d,
                         output bit er, output logic [63:0] rd);
        er = (a % 8 != 0) || (a >= 64'(DEPTH * 8));
        rd = '0;
        if (!er) begin
            if (w) mdl[k][a / 8] = d;
            else   rd = mdl[k][a / 8];
        end
    endtask

    // One full transaction starting and ending at a negedge; checks latency, data, error, hold stability.
    task automatic txn(input string nm, input int k, input bit w, input logic [63:0] a,
                       input logic [63:0] d, input int hold);
        bit          er;
        logic [63:0] rd;
        int          n;
        int          lat;
        model(k, w, a, d, er, rd);
        req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
        rsp_ready[k] = (hold == 0);
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[k] = 1'b0;
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        chk({nm, "_latency"}, 64'(lat), 64'(lat_of(k)));
        chk({nm, "_rdata"}, rsp_rdata[k], rd);
        chk({nm, "_error"}, 64'(rsp_error[k]), 64'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(rsp_valid[k]), 64'd1);
            chk({nm, "_hold_rdata"}, rsp_rdata[k], rd);
            chk({nm, "_hold_error"}, 64'(rsp_error[k]), 64'(er));
            chk({nm, "_hold_ready"}, 64'(req_ready[k]), 64'd0);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        if (hold > 0) begin
            chk({nm, "_release_valid"}, 64'(rsp_valid[k]), 64'd0);
            chk({nm, "_release_ready"}, 64'(req_ready[k]), 64'd1);
        end
    endtask

    // Continuous req_valid for 4 loads of words 0..3; checks acceptance spacing and response order.
    task automatic burst(input int k);
        int          acc [4];
        logic [63:0] exp [4];
        bit          er;
        int          cyc, nacc, nrsp;
        bit          will_acc;
        for (int i = 0; i < 4; i++) model(k, 1'b0, 64'(i * 8), '0, er, exp[i]);
        req_valid[k] = 1'b1; req_write[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b1;
        cyc = 0; nacc = 0; nrsp = 0;
        while (nrsp < 4 && cyc < 100) begin
            if (rsp_valid[k] === 1'b1) begin
                chk($sformatf("burst%0d_rsp%0d", k, nrsp), rsp_rdata[k], exp[nrsp]);
                nrsp++;
            end
            will_acc = (req_valid[k] === 1'b1) && (req_ready[k] === 1'b1);
            @(negedge clk);
            cyc++;
            if (will_acc) begin
                acc[nacc] = cyc;
                nacc++;
                if (nacc == 4) req_valid[k] = 1'b0;
                else           req_addr[k] = 64'(nacc * 8);
            end
        end
        rsp_ready[k] = 1'b0;
        chk($sformatf("burst%0d_responses", k), 64'(nrsp), 64'd4);
        if (nacc == 4) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("burst%0d_spacing%0d", k, i), 64'(acc[i+1] - acc[i]),
                    64'(lat_of(k) + 1));
        end
    endtask

    initial begin
        vec_t        vt [12];
        bit          er;
        logic [63:0] rd;
        int          n;

        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0;  rsp_ready[k] = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mdl[k][i] = '0;
        end

        vt[0]  = '{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0};
        vt[1]  = '{1'b0, 64'h10,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
        vt[2]  = '{1'b0, 64'h13,  64'h0,                 1'b1, 64'h0};
        vt[3]  = '{1'b1, 64'h800, 64'h1111_2222_3333_4444, 1'b1, 64'h0};
        vt[4]  = '{1'b0, 64'h0,   64'h0,                 1'b0, 64'h0};
        vt[5]  = '{1'b1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
        vt[6]  = '{1'b0, 64'h7F8, 64'h0,                 1'b0, 64'h0123_4567_89AB_CDEF};
        vt[7]  = '{1'b1, 64'h14,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
        vt[8]  = '{1'b0, 64'h10,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D};
        vt[9]  = '{1'b0, 64'h8000_0000_0000_0010, 64'h0, 1'b1, 64'h0};
        vt[10] = '{1'b1, 64'h8,   64'h5555_AAAA_5555_AAAA, 1'b0, 64'h0};
        vt[11] = '{1'b0, 64'h8,   64'h0,                 1'b0, 64'h5555_AAAA_5555_AAAA};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset%0d_req_ready", k), 64'(req_ready[k]), 64'd1);
            chk($sformatf("reset%0d_rsp_valid", k), 64'(rsp_valid[k]), 64'd0);
            chk($sformatf("reset%0d_rsp_rdata", k), rsp_rdata[k], 64'd0);
            chk($sformatf("reset%0d_rsp_error", k), 64'(rsp_error[k]), 64'd0);
        end

        // Directed table against hand-derived expectations, then the model stays in sync.
        for (int i = 0; i < 12; i++) begin
            model(0, vt[i].w, vt[i].addr, vt[i].wdata, er, rd);
            chk($sformatf("vec%0d_model_err", i), 64'(er), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_model_rdata", i), rd, vt[i].exp_rdata);
            if (vt[i].w) mdl[0][vt[i].addr / 8] = (vt[i].exp_err) ? mdl[0][vt[i].addr / 8]
                                                                : mdl[0][vt[i].addr / 8];
            // Undo the model write so txn re-applies it with the DUT transaction.
            if (vt[i].w && !vt[i].exp_err) mdl[0][vt[i].addr / 8] = (i == 0) ? 64'h0 :
                (i == 5) ? 64'h0 : (i == 10) ? 64'h0 : mdl[0][vt[i].addr / 8];
            txn($sformatf("vec%0d", i), 0, vt[i].w, vt[i].addr, vt[i].wdata, 0);
        end

        // Response held for 5 cycles with rsp_ready low.
        txn("hold_load", 0, 1'b0, 64'h10, '0, 5);

        // Reset during BUSY: the store must not commit and no response appears.
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h20;
        req_wdata[0] = 64'hABCD_0000_1234_5678;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy_reset_rsp_valid", 64'(rsp_valid[0]), 64'd0);
            chk("busy_reset_req_ready", 64'(req_ready[0]), 64'd1);
            @(negedge clk);
        end
        txn("busy_reset_reload", 0, 1'b0, 64'h20, '0, 0);

        // Reset during RESP: response dropped, committed store kept.
        model(0, 1'b1, 64'h28, 64'h0F0F_F0F0_0F0F_F0F0, er, rd);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h28;
        req_wdata[0] = 64'h0F0F_F0F0_0F0F_F0F0; rsp_ready[0] = 1'b0;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
            if (req_ready[0] !== 1'b1) req_valid[0] = 1'b0;
        end
        chk("resp_reset_reached_resp", 64'(rsp_valid[0]), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("resp_reset_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("resp_reset_req_ready", 64'(req_ready[0]), 64'd1);
        txn("resp_reset_reload", 0, 1'b0, 64'h28, '0, 0);

        // Back-to-back spacing at LATENCY 1 and 3, preloading words 0..3 first.
        for (int k = 1; k < NI; k++) begin
            for (int i = 0; i < 4; i++)
                txn($sformatf("pre%0d_%0d", k, i), k, 1'b1, 64'(i * 8), 64'({$urandom, $urandom}), 0);
            burst(k);
        end

        // Random traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            int          r;
            logic [63:0] a;
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 64'($urandom_range(0, 31) * 8);
            else if (r == 7) a = 64'($urandom_range(0, 31) * 8 + $urandom_range(1, 7));
            else if (r == 8) a = 64'(2048 + $urandom_range(0, 255) * 8);
            else             a = {$urandom, $urandom};
            txn($sformatf("rand%0d", t), 0, 1'($urandom_range(0, 1)), a,
                {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
